// File: rtl/mat_pkg.sv
// Shared matrix-unit types: data-read opcodes and instruction-fetch FSM states.
package mat_pkg;

    localparam int unsigned MAT_INST_MEM_SIZE       = 1024;
    localparam int unsigned MAT_INST_MEM_ADDR_SIZE  = 32;
    localparam int unsigned MAT_INST_MEM_WIDTH_SIZE = 128;
    localparam int unsigned MAT_FETCH_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        MAT_READ_NONE,
        MAT_READ_ROW,
        MAT_READ_COL,
        MAT_READ_DIAG
    } MatDataReadOp_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL,
        END
    } MatFetchState_t;

endpackage

// File: rtl/mat_inst_fifo.sv
// Prefetch buffer: circular FIFO with a registered head entry and synchronous flush.
module mat_inst_fifo #(
    parameter int unsigned WIDTH = 160,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head_data;
    logic             r_head_valid;

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_data_nxt;

    // Next pointers/count; head is looked ahead so it can be registered
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            w_count_nxt = r_count + CNT_W'(push) - CNT_W'(pop);
        end
        w_head_data_nxt = r_mem[w_rd_ptr_nxt];
        // Entry being written this cycle becomes the head when it is the only one left
        if (push && !flush && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_data_nxt = push_data;
        end
    end

    // Storage array write; contents need no reset
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer, count and head registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_data  <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_head_data  <= w_head_data_nxt;
            r_head_valid <= (w_count_nxt != '0);
        end
    end

    assign head_data   = r_head_data;
    assign head_valid  = r_head_valid;
    assign count       = r_count;
    assign count_nxt_c = w_count_nxt;

endmodule

// File: rtl/mat_inst_fetch.sv
// Instruction fetch: PC + FSM streaming instruction words into a prefetch buffer.
module mat_inst_fetch
    import mat_pkg::*;
#(
    parameter int unsigned INST_MEM_SIZE       = MAT_INST_MEM_SIZE,
    parameter int unsigned INST_MEM_ADDR_SIZE  = MAT_INST_MEM_ADDR_SIZE,
    parameter int unsigned INST_MEM_WIDTH_SIZE = MAT_INST_MEM_WIDTH_SIZE,
    parameter int unsigned FIFO_DEPTH          = MAT_FETCH_FIFO_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  start_pc,
    input  logic                           redirect,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_pc,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_read_addr,
    input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_data_out,
    output logic [INST_MEM_WIDTH_SIZE-1:0] inst,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_pc,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic                           done
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = INST_MEM_WIDTH_SIZE + INST_MEM_ADDR_SIZE;
    localparam logic [INST_MEM_ADDR_SIZE-1:0] LAST_PC = INST_MEM_ADDR_SIZE'(INST_MEM_SIZE - 1);
    localparam logic [INST_MEM_ADDR_SIZE-1:0] END_PC  = INST_MEM_ADDR_SIZE'(INST_MEM_SIZE);
    localparam logic [CNT_W-1:0]              DEPTH_C = CNT_W'(FIFO_DEPTH);

    MatFetchState_t                r_state;
    MatFetchState_t                w_state_nxt;
    logic [INST_MEM_ADDR_SIZE-1:0] r_pc;
    logic [INST_MEM_ADDR_SIZE-1:0] w_pc_nxt;
    logic                          r_done;

    logic                          w_push;
    logic                          w_pop;
    logic [ENTRY_W-1:0]            w_push_entry;
    logic [ENTRY_W-1:0]            w_head_entry;
    logic [CNT_W-1:0]              w_count;
    logic [CNT_W-1:0]              w_count_nxt;

    // A redirect discards the same-cycle handshake, so it never pops
    assign w_pop        = inst_valid && inst_ready && !redirect;
    assign w_push_entry = {inst_mem_data_out, r_pc};

    // Next-state, next-PC and push decision
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = (redirect_pc >= END_PC) ? END : FETCH;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_pc_nxt    = start_pc;
                        w_state_nxt = (start_pc >= END_PC) ? END : FETCH;
                    end
                end
                FETCH: begin
                    if ((w_count < DEPTH_C) || w_pop) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + INST_MEM_ADDR_SIZE'(1);
                        if (r_pc == LAST_PC) w_state_nxt = END;
                    end else begin
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (w_pop) w_state_nxt = FETCH;
                end
                END: begin
                    w_state_nxt = END;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, PC and done registers; done is looked ahead to line up with END and empty
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= (w_state_nxt == END) && (w_count_nxt == '0);
        end
    end

    mat_inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush       (redirect),
        .push        (w_push),
        .push_data   (w_push_entry),
        .pop         (w_pop),
        .head_data   (w_head_entry),
        .head_valid  (inst_valid),
        .count       (w_count),
        .count_nxt_c (w_count_nxt)
    );

    assign inst               = w_head_entry[ENTRY_W-1 -: INST_MEM_WIDTH_SIZE];
    assign inst_pc            = w_head_entry[INST_MEM_ADDR_SIZE-1:0];
    assign inst_mem_read_addr = r_pc;
    assign done               = r_done;

endmodule

// File: tb/tb_mat_inst_fetch.sv
// Directed bench for mat_inst_fetch with a scoreboard of expected delivered PCs.
module tb_mat_inst_fetch;
    import mat_pkg::*;

    localparam int unsigned A = 32;
    localparam int unsigned W = 128;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [A-1:0] start_pc;
    logic         redirect;
    logic [A-1:0] redirect_pc;
    logic [A-1:0] inst_mem_read_addr;
    logic [W-1:0] inst_mem_data_out;
    logic [W-1:0] inst;
    logic [A-1:0] inst_pc;
    logic         inst_valid;
    logic         inst_ready;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    logic [A-1:0] exp_q[$];

    always #5 clock = ~clock;

    // Behavioural instruction memory: word k holds value k
    assign inst_mem_data_out = W'(inst_mem_read_addr);

    mat_inst_fetch dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .start_pc           (start_pc),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .inst_mem_read_addr (inst_mem_read_addr),
        .inst_mem_data_out  (inst_mem_data_out),
        .inst               (inst),
        .inst_pc            (inst_pc),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .done               (done)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_run(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(A'(first + i));
    endtask

    // Score a pending handshake, then advance one clock and settle past the edge
    task automatic step();
        logic [A-1:0] e;
        if (!reset && !redirect && inst_valid && inst_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed pc %0d expected no delivery", inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", 160'(inst_pc), 160'(e));
                check("sb_inst", 160'(inst), 160'(e));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        start_pc    = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        step();
        step();

        // Reset values
        check("rst_valid", 160'(inst_valid), 160'(0));
        check("rst_done", 160'(done), 160'(0));
        check("rst_inst_pc", 160'(inst_pc), 160'(0));
        check("rst_inst", 160'(inst), 160'(0));
        check("rst_addr", 160'(inst_mem_read_addr), 160'(0));
        check("rst_state", 160'(dut.r_state), 160'(IDLE));
        reset = 1'b0;
        step();
        check("idle_hold", 160'(dut.r_state), 160'(IDLE));

        // V1: stream from 0 with consumer always ready
        expect_run(0, 12);
        start = 1'b1; start_pc = '0; inst_ready = 1'b1;
        step();
        start = 1'b0;
        check("v1_state", 160'(dut.r_state), 160'(FETCH));
        check("v1_no_valid_yet", 160'(inst_valid), 160'(0));
        step();
        check("v1_first_valid", 160'(inst_valid), 160'(1));
        check("v1_first_pc", 160'(inst_pc), 160'(0));
        for (int i = 0; i < 8; i++) begin
            step();
            check("v1_stream_valid", 160'(inst_valid), 160'(1));
        end
        do_reset();

        // V2: fill buffer with consumer stalled, then drain
        start = 1'b1; start_pc = A'(10); inst_ready = 1'b0;
        step();
        start = 1'b0;
        expect_run(10, 8);
        for (int i = 0; i < 8; i++) step();
        check("v2_state_full", 160'(dut.r_state), 160'(FULL));
        check("v2_pc", 160'(inst_mem_read_addr), 160'(14));
        check("v2_count", 160'(dut.u_fifo.r_count), 160'(4));
        check("v2_head_stable", 160'(inst_pc), 160'(10));
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("v2_drain_valid", 160'(inst_valid), 160'(1));
        end

        // V5: get back to FULL, then reset out of it
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("v5_state_full", 160'(dut.r_state), 160'(FULL));
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check("v5_valid", 160'(inst_valid), 160'(0));
        check("v5_done", 160'(done), 160'(0));
        check("v5_state", 160'(dut.r_state), 160'(IDLE));
        start = 1'b1; start_pc = A'(5); inst_ready = 1'b1;
        step();
        start = 1'b0;
        expect_run(5, 6);
        step();
        check("v5_first_pc", 160'(inst_pc), 160'(5));
        for (int i = 0; i < 5; i++) step();
        do_reset();

        // V4: redirect with three entries buffered
        start = 1'b1; start_pc = A'(40); inst_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("v4_count", 160'(dut.u_fifo.r_count), 160'(3));
        check("v4_head", 160'(inst_pc), 160'(40));
        redirect = 1'b1; redirect_pc = A'(100); inst_ready = 1'b1;
        exp_q.delete();
        expect_run(100, 6);
        step();
        redirect = 1'b0;
        check("v4_flush_valid", 160'(inst_valid), 160'(0));
        check("v4_pc", 160'(inst_mem_read_addr), 160'(100));
        check("v4_state", 160'(dut.r_state), 160'(FETCH));
        step();
        check("v4_first_pc", 160'(inst_pc), 160'(100));
        for (int i = 0; i < 5; i++) step();
        do_reset();

        // V6: start and redirect together in IDLE
        start = 1'b1; start_pc = '0; redirect = 1'b1; redirect_pc = A'(50); inst_ready = 1'b1;
        step();
        start = 1'b0; redirect = 1'b0;
        check("v6_pc", 160'(inst_mem_read_addr), 160'(50));
        check("v6_state", 160'(dut.r_state), 160'(FETCH));
        expect_run(50, 5);
        step();
        check("v6_first_pc", 160'(inst_pc), 160'(50));
        for (int i = 0; i < 4; i++) step();
        do_reset();

        // V3: run off the end of instruction memory
        start = 1'b1; start_pc = A'(1020); inst_ready = 1'b1;
        step();
        start = 1'b0;
        expect_run(1020, 4);
        step();
        step();
        check("v3_not_done_yet", 160'(done), 160'(0));
        for (int i = 0; i < 4; i++) step();
        check("v3_done", 160'(done), 160'(1));
        check("v3_valid", 160'(inst_valid), 160'(0));
        check("v3_state", 160'(dut.r_state), 160'(END));
        check("v3_drained", 160'(exp_q.size()), 160'(0));
        start = 1'b1; start_pc = '0;
        step();
        start = 1'b0;
        check("v3_start_ignored", 160'(dut.r_state), 160'(END));
        for (int i = 0; i < 3; i++) begin
            step();
            check("v3_done_held", 160'(done), 160'(1));
            check("v3_no_valid", 160'(inst_valid), 160'(0));
        end
        redirect = 1'b1; redirect_pc = A'(2000);
        step();
        redirect = 1'b0;
        check("v3_redir_oob_state", 160'(dut.r_state), 160'(END));
        check("v3_redir_oob_done", 160'(done), 160'(1));
        check("v3_redir_oob_pc", 160'(inst_mem_read_addr), 160'(2000));
        check("v3_redir_oob_valid", 160'(inst_valid), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
